mips_fetch_unit: RTL and testbench

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

---
 rtl/mips_fetch_unit_pkg.sv | 16 +
 rtl/fetch_timeout_counter.sv | 31 +++
 rtl/mips_fetch_unit.sv | 81 ++++++++
 tb/tb_mips_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_unit_pkg.sv
// Shared definitions for the MIPS instruction fetch unit and the multicycle CPU that reuses them.
package mips_fetch_unit_pkg;

  // StPend is the post-reset cycle: the unit is about to fetch but does not request yet.
  typedef enum logic [1:0] {
    StPend,
    StFetch,
    StDeliver,
    StFault
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam int unsigned DefaultTimeout = 255;
  localparam int unsigned TimeoutWidth   = 8;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts FETCH cycles spent waiting for an ack; flags the cycle that would reach TIMEOUT.
module fetch_timeout_counter
  import mips_fetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TimeoutWidth-1:0] LastCount = TimeoutWidth'(TIMEOUT - 1);

  logic [TimeoutWidth-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TimeoutWidth'(1);
    end
  end

  // r_count holds the ack-less cycles already elapsed, so this cycle would be number TIMEOUT.
  assign o_expired = i_enable && (r_count == LastCount);

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch front end: requests the word at pc, delivers it for one cycle, then loads pc_new.
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned TIMEOUT  = DefaultTimeout
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_new,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_fault,
  output logic [31:0] o_retired
);

  fetch_state_e r_state, w_state_next;
  logic [31:0]  r_pc, r_instr, r_retired;
  logic         w_in_fetch, w_misaligned, w_ack, w_expired;

  assign w_in_fetch   = (r_state == StFetch);
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  // A misaligned pc never reaches memory; the FSM faults straight out of FETCH.
  assign o_mem_req    = w_in_fetch && !w_misaligned;
  assign w_ack        = o_mem_req && i_mem_ack;

  fetch_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (!w_in_fetch),
    .i_enable (o_mem_req && !i_mem_ack),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StPend:    w_state_next = StFetch;
      StFetch: begin
        if (w_misaligned)   w_state_next = StFault;
        else if (w_ack)     w_state_next = StDeliver;
        else if (w_expired) w_state_next = StFault;
      end
      StDeliver: w_state_next = StFetch;
      StFault:   w_state_next = StFault;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StPend;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ack) begin
        r_instr <= i_mem_rdata;
      end
      if (r_state == StDeliver) begin
        r_pc      <= i_pc_new;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_mem_addr    = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = (r_state == StDeliver);
  assign o_fault       = (r_state == StFault);
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against a transaction-level model of pc, instr and retired.
module tb_mips_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Tmo     = 255;

  logic        clk, reset, instr_valid, mem_req, mem_ack, fault;
  logic [31:0] pc_new, pc, instr, mem_addr, mem_rdata, retired;

  int          n_checks, n_fail;
  logic [31:0] m_pc, m_ret, last_word, tmp;

  mips_fetch_unit #(
    .RESET_PC(ResetPc),
    .TIMEOUT (Tmo)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_pc_new     (pc_new),
    .o_pc         (pc),
    .o_instr      (instr),
    .o_instr_valid(instr_valid),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_fault      (fault),
    .o_retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction memory contents: one fixed word plus an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h2008_0005;
    return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1234};
  endfunction

  task automatic do_reset(input logic stale_ack);
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = stale_ack;
    #1;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_pc", pc, ResetPc);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_retired", retired, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    m_pc      = ResetPc;
    m_ret     = 32'd0;
    last_word = 32'd0;
    check("pend_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
  endtask

  // Entered at the negedge of the first FETCH cycle; returns at the negedge of the next one.
  task automatic run_fetch(input int wait_cyc, input logic [31:0] pcn);
    for (int w = 0; w <= wait_cyc; w++) begin
      check("fetch_req", {31'd0, mem_req}, 32'd1);
      check("fetch_addr", mem_addr, m_pc);
      check("fetch_valid", {31'd0, instr_valid}, 32'd0);
      if (w == 0) check("fetch_instr_hold", instr, last_word);
      mem_ack   = (w == wait_cyc);
      mem_rdata = mem_ack ? mem_word(m_pc) : $urandom;
      pc_new    = $urandom;
      @(negedge clk);
    end
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    pc_new    = pcn;
    check("dlv_valid", {31'd0, instr_valid}, 32'd1);
    check("dlv_instr", instr, mem_word(m_pc));
    check("dlv_req", {31'd0, mem_req}, 32'd0);
    check("dlv_pc", pc, m_pc);
    check("dlv_retired", retired, m_ret);
    check("dlv_fault", {31'd0, fault}, 32'd0);
    last_word = mem_word(m_pc);
    m_pc      = pcn;
    m_ret     = m_ret + 32'd1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("next_pc", pc, m_pc);
    check("next_retired", retired, m_ret);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    pc_new    = 32'd0;

    // Zero-wait fetch from reset, then a 5-cycle wait on the fixed word.
    do_reset(1'b0);
    run_fetch(0, 32'h0000_0004);
    run_fetch(5, 32'h0000_0100);

    for (int i = 0; i < 30; i++) begin
      tmp = $urandom;
      run_fetch(int'($urandom_range(0, 6)), {tmp[31:2], 2'b00});
    end

    // Ack on the last permitted cycle wins over the timeout.
    run_fetch(Tmo - 1, 32'h0000_0200);

    // No ack at all: request holds for TIMEOUT cycles, then sticky fault.
    for (int w = 0; w < Tmo; w++) begin
      check("tmo_req", {31'd0, mem_req}, 32'd1);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      check("tmo_fault", {31'd0, fault}, 32'd1);
      check("tmo_req_off", {31'd0, mem_req}, 32'd0);
      check("tmo_valid", {31'd0, instr_valid}, 32'd0);
      check("tmo_pc_hold", pc, m_pc);
      check("tmo_ret_hold", retired, m_ret);
      @(negedge clk);
    end

    // Reset mid-handshake drops the request at once; a stale ack afterwards is ignored.
    do_reset(1'b0);
    run_fetch(2, 32'h0000_0100);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    mem_ack = 1'b1;
    #1;
    check("midrst_req", {31'd0, mem_req}, 32'd0);
    do_reset(1'b1);
    mem_ack = 1'b0;
    run_fetch(1, 32'h0000_0008);

    // Retired counter wraps without faulting.
    do_reset(1'b0);
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    m_ret = 32'hFFFF_FFFF;
    check("wrap_pre", retired, 32'hFFFF_FFFF);
    run_fetch(2, 32'h0000_0040);
    check("wrap_zero", retired, 32'd0);
    check("wrap_fault", {31'd0, fault}, 32'd0);

    // Misaligned pc_new: next FETCH never requests and faults permanently.
    run_fetch(1, 32'h0000_0006);
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      check("mis_req", {31'd0, mem_req}, 32'd0);
      if (i > 0) check("mis_fault", {31'd0, fault}, 32'd1);
      check("mis_pc", pc, 32'h0000_0006);
      check("mis_ret", retired, m_ret);
      @(negedge clk);
    end
    do_reset(1'b0);
    check("post_rst_fault", {31'd0, fault}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
